dbus2ocp3: RTL
==============

Name: dbus2ocp3

Overview:
- Next-generation CPU data-bus to OCP master converter.
- Generalised in address, data and byte-enable width.
- Adds a DEPTH-entry command queue, so the CPU can post several requests while the slave stalls.
- Bounds in-flight transactions and reports busy/protocol status for fences.
- Sits between the CPU core data port and the OCP interconnect.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8)
BEN_W, DATA_W/8, byte-enable width
DEPTH, 4, command queue entries (power of 2, >=2)
MAX_OUT, 4, max requests queued plus issued-awaiting-response (1..255)

Ports:
clk  in  1  clock
nrst  in  1  asynchronous reset, active-low
i_DAddr  in  ADDR_W  CPU address
i_DCmd  in  1  CPU request valid
i_DRnW  in  1  1=read, 0=write
i_DBen  in  BEN_W  CPU byte enables
i_DData  in  DATA_W  CPU write data
o_DAccept  out  1  converter takes request this cycle
o_DData  out  DATA_W  read data to CPU
o_DRdy  out  1  response valid to CPU
o_DErr  out  1  response is error
o_Busy  out  1  queue non-empty or responses pending
o_ProtoErr  out  1  sticky: response received with none pending
o_MAddr  out  ADDR_W  OCP address
o_MCmd  out  3  OCP command
o_MData  out  DATA_W  OCP write data
o_MByteEn  out  BEN_W  OCP byte enables
i_SCmdAccept  in  1  OCP command accept
i_SData  in  DATA_W  OCP read data
i_SResp  in  2  OCP response

Behaviour:
- Encodings: MCmd IDLE=3'b000, WRITE=3'b001, READ=3'b010. SResp NULL=2'b00, DVA=2'b01, FAIL=2'b10, ERR=2'b11.
- Reset (nrst low, async):
  - Queue emptied; pending counter = 0; o_ProtoErr = 0.
  - Outputs: o_MCmd IDLE, o_MAddr/o_MData/o_MByteEn all zero, o_Busy 0, o_DAccept 0 while nrst is low.
- o_DAccept = !full && (pending < MAX_OUT). Computed from registered state only, with no combinational path from i_SCmdAccept or i_SResp.
- Push: i_DCmd && o_DAccept stores {addr, cmd, ben, data} into the tail. Data is stored for writes; don't-care for reads.
- OCP head:
  - When the queue is non-empty, o_M* present the head entry.
  - When empty, o_MCmd = IDLE and the other o_M* hold the last head values.
  - No bypass: a request pushed in cycle N appears on OCP in cycle N+1 at the earliest.
- Pop: head valid && i_SCmdAccept. Next entry, if any, is presented the following cycle. Head fields stay stable until popped (OCP hold rule).
- pending counter:
  - +1 on push.
  - -1 on a response (i_SResp != NULL) while pending > 0.
  - Simultaneous push and response: net 0.
  - Counter width clog2(MAX_OUT+1).
- Response with pending == 0: counter stays 0; o_ProtoErr set (sticky until reset).
- Response path is combinational pass-through:
  - o_DData = i_SData.
  - o_DRdy = (i_SResp != NULL).
  - o_DErr = (i_SResp == ERR || i_SResp == FAIL).
- Responses return in issue order; the block does not reorder.
- o_Busy = queue non-empty || pending != 0. Registered-state based.
- Full queue: o_DAccept = 0. A pop in the same cycle does not enable a push until the next cycle.
- Pointers wrap modulo DEPTH. Full/empty are distinguished by an extra pointer bit.
- Reset mid-transaction: queued and in-flight requests are discarded. Responses arriving after reset set o_ProtoErr.

Test Plan:
- Single read, slave accepts at once:
  - Stimulus: DCmd=1, RnW=1, Addr=0x1000, Ben=4'hF; SCmdAccept=1; SResp=DVA, SData=0xCAFEF00D two cycles later.
  - Required: MCmd=READ, MAddr=0x1000 in cycle N+1. DRdy=1, DData=0xCAFEF00D, DErr=0 in the response cycle. Busy drops to 0 the cycle after.
- Queue fill under stall (DEPTH=4, MAX_OUT=4):
  - Stimulus: SCmdAccept=0; push writes to 0x0,0x4,0x8,0xC with data 1..4.
  - Required: DAccept=0 after the 4th push. MCmd=WRITE, MAddr=0x0, MData=1 held stable. On SCmdAccept=1, entries issue one per cycle in order 0x0,0x4,0x8,0xC.
- MAX_OUT limit (MAX_OUT=2):
  - Stimulus: two reads accepted and issued, no response yet.
  - Required: DAccept=0. After one DVA response, DAccept=1 the next cycle.
- Error responses:
  - Stimulus: SResp=ERR, then SResp=FAIL.
  - Required: DRdy=1 and DErr=1 on both; pending decrements on both.
- Protocol error:
  - Stimulus: SResp=DVA with pending=0.
  - Required: o_ProtoErr=1 and held; pending stays 0.
- Reset mid-operation:
  - Stimulus: 3 entries queued, nrst pulsed low.
  - Required: MCmd=IDLE immediately (async). After release: Busy=0, DAccept=1, queue empty.

Source files
------------

// File: rtl/dbus2ocp3.sv
// CPU data-bus to OCP master bridge: posted-request command queue with an
// outstanding-transaction limit, in-order pass-through responses and status flags.
module dbus2ocp3 #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int BEN_W   = DATA_W / 8,
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [ADDR_W-1:0] i_DAddr,
    input  logic              i_DCmd,
    input  logic              i_DRnW,
    input  logic [BEN_W-1:0]  i_DBen,
    input  logic [DATA_W-1:0] i_DData,
    output logic              o_DAccept,
    output logic [DATA_W-1:0] o_DData,
    output logic              o_DRdy,
    output logic              o_DErr,
    output logic              o_Busy,
    output logic              o_ProtoErr,
    output logic [ADDR_W-1:0] o_MAddr,
    output logic [2:0]        o_MCmd,
    output logic [DATA_W-1:0] o_MData,
    output logic [BEN_W-1:0]  o_MByteEn,
    input  logic              i_SCmdAccept,
    input  logic [DATA_W-1:0] i_SData,
    input  logic [1:0]        i_SResp
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(MAX_OUT + 1);

    typedef enum logic [2:0] {
        MCMD_IDLE  = 3'b000,
        MCMD_WRITE = 3'b001,
        MCMD_READ  = 3'b010
    } mcmd_e;

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic              mem_rnw  [DEPTH];
    logic [BEN_W-1:0]  mem_ben  [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     pending_q, pending_d;
    logic              proto_err_q, proto_err_d;
    logic              accept_q, accept_d;
    logic              busy_q, busy_d;
    mcmd_e             m_cmd_q, m_cmd_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [BEN_W-1:0]  m_ben_q, m_ben_d;

    logic push, pop, resp, empty_d, full_d;
    logic [AW-1:0] head_idx;

    assign push = i_DCmd && accept_q;
    assign pop  = (wr_ptr_q != rd_ptr_q) && i_SCmdAccept;
    assign resp = (i_SResp != 2'b00);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wr_ptr_d    = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d    = rd_ptr_q + (AW+1)'(pop);
        pending_d   = pending_q;
        proto_err_d = proto_err_q;
        m_cmd_d     = MCMD_IDLE;
        m_addr_d    = m_addr_q;
        m_data_d    = m_data_q;
        m_ben_d     = m_ben_q;
        head_idx    = rd_ptr_d[AW-1:0];

        if (resp && pending_q == '0)
            proto_err_d = 1'b1;
        case ({push, resp && (pending_q != '0)})
            2'b10:   pending_d = pending_q + PW'(1);
            2'b01:   pending_d = pending_q - PW'(1);
            default: pending_d = pending_q;
        endcase

        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                  (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);

        // Next head is the slot being written this cycle only when the queue drains onto it.
        if (!empty_d) begin
            if (push && (rd_ptr_d == wr_ptr_q)) begin
                m_cmd_d  = i_DRnW ? MCMD_READ : MCMD_WRITE;
                m_addr_d = i_DAddr;
                m_data_d = i_DData;
                m_ben_d  = i_DBen;
            end else begin
                m_cmd_d  = mem_rnw[head_idx] ? MCMD_READ : MCMD_WRITE;
                m_addr_d = mem_addr[head_idx];
                m_data_d = mem_data[head_idx];
                m_ben_d  = mem_ben[head_idx];
            end
        end

        accept_d = !full_d && (pending_d < PW'(MAX_OUT));
        busy_d   = !empty_d || (pending_d != '0);
    end

    always_ff @(posedge clk or negedge nrst) begin
        // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
        if (!nrst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pending_q   <= '0;
            proto_err_q <= 1'b0;
            accept_q    <= 1'b0;
            busy_q      <= 1'b0;
            m_cmd_q     <= MCMD_IDLE;
            m_addr_q    <= '0;
            m_data_q    <= '0;
            m_ben_q     <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pending_q   <= pending_d;
            proto_err_q <= proto_err_d;
            accept_q    <= accept_d;
            busy_q      <= busy_d;
            m_cmd_q     <= m_cmd_d;
            m_addr_q    <= m_addr_d;
            m_data_q    <= m_data_d;
            m_ben_q     <= m_ben_d;
        end
    end

    // NOTE: queue storage has no reset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr_q[AW-1:0]] <= i_DAddr;
            mem_rnw[wr_ptr_q[AW-1:0]]  <= i_DRnW;
            mem_ben[wr_ptr_q[AW-1:0]]  <= i_DBen;
            mem_data[wr_ptr_q[AW-1:0]] <= i_DData;
        end
    end

    assign o_DAccept  = accept_q;
    assign o_Busy     = busy_q;
    assign o_ProtoErr = proto_err_q;
    assign o_MCmd     = m_cmd_q;
    assign o_MAddr    = m_addr_q;
    assign o_MData    = m_data_q;
    assign o_MByteEn  = m_ben_q;

    // FAIL (2'b10) and ERR (2'b11) are the only codes with the top bit set.
    assign o_DData = i_SData;
    assign o_DRdy  = resp;
    assign o_DErr  = i_SResp[1];

endmodule
